// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - pipeline stage register with valid/ready handshake and 2-entry skid buffer
module pipe_stage_skid_reg #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [1:0]        occ_q;

  // Handshake events; in_ready_q comes straight from a flop so upstream never
  // sees a combinational path from out_ready.
  logic acc;
  logic pop;
  assign acc = in_valid & in_ready_q;
  assign pop = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

  // State machine: main/skid storage plus registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= FLUSH_VAL;
      skid_q      <= FLUSH_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else if (flush) begin
      // Incoming payload is dropped even if accepted; a same-cycle pop has
      // already been consumed downstream, so nothing needs to be kept.
      state_q     <= EMPTY;
      main_q      <= FLUSH_VAL;
      skid_q      <= FLUSH_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_q     <= ONE;
            main_q      <= in_data;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
          end
        end
        ONE: begin
          case ({acc, pop})
            2'b11: begin
              main_q <= in_data;
            end
            2'b10: begin
              // Downstream stalled: park the new payload behind main.
              state_q    <= TWO;
              skid_q     <= in_data;
              in_ready_q <= 1'b0;
              occ_q      <= 2'd2;
            end
            2'b01: begin
              // main_q keeps its stale value; out_valid masks it.
              state_q     <= EMPTY;
              out_valid_q <= 1'b0;
              occ_q       <= 2'd0;
            end
            default: begin
            end
          endcase
        end
        TWO: begin
          if (pop) begin
            state_q    <= ONE;
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - scoreboard bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

  localparam int          DW = 64;
  localparam logic [63:0] FV = 64'h0000_0000_F1F1_F1F1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [1:0]    occupancy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb[$];

  pipe_stage_skid_reg #(.DATA_W(DW), .FLUSH_VAL(FV)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs are stable by the falling edge, so a pop at the next
  // rising edge is known here; compare it against the scoreboard head.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %h expected no output", out_data);
      end else begin
        chk("pop_data", out_data, sb.pop_front());
      end
    end
    if (!reset || flush) sb.delete();
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_out_data"},  out_data,       FV);
    chk({tag, "_occ"},       64'(occupancy), 64'd0);
  endtask

  int occ_m;

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'hAAAA; out_ready = 1'b0;
    #1;
    // 1. reset with traffic offered
    repeat (2) step();
    chk_reset_state("rst");
    reset = 1'b1; in_valid = 1'b0;
    step();
    chk("idle_occ", 64'(occupancy), 64'd0);

    // 2. back-to-back stream
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      sb.push_back(64'(i));
      step();
      chk("stream_data", out_data, 64'(i));
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_occ", 64'(occupancy), 64'd0);

    // 3. backpressure into the skid entry
    out_ready = 1'b0;
    sb.push_back(64'h10); sb.push_back(64'h11); sb.push_back(64'h12);
    in_valid = 1'b1; in_data = 64'h10; step();
    chk("bp_occ1", 64'(occupancy), 64'd1);
    chk("bp_ready1", 64'(in_ready), 64'd1);
    in_data = 64'h11; step();
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_ready2", 64'(in_ready), 64'd0);
    in_data = 64'h12; step();
    chk("bp_hold_occ", 64'(occupancy), 64'd2);
    chk("bp_hold_data", out_data, 64'h10);
    out_ready = 1'b1; step();
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_data", out_data, 64'h11);
    step();
    chk("bp_last_data", out_data, 64'h12);
    in_valid = 1'b0; step();
    chk("bp_drain_occ", 64'(occupancy), 64'd0);

    // 4. flush while full; flushed payloads must never emerge
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h20; step();
    in_data = 64'h21; step();
    chk("fl_full_occ", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = 64'h22; step();
    chk_reset_state("flush");
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("fl_after_occ", 64'(occupancy), 64'd0);

    // 5. reset beats flush and traffic, then streaming resumes
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h30; step();
    reset = 1'b0; flush = 1'b1; in_data = 64'hAAAA;
    repeat (2) step();
    chk_reset_state("rst2");
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h40; sb.push_back(64'h40);
    step();
    chk("resume_data", out_data, 64'h40);
    chk("resume_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0; step();

    // 6. random valid/ready/flush against an occupancy model
    occ_m = 0;
    for (int c = 0; c < 3000; c++) begin
      logic acc_m, pop_m;
      chk("rnd_in_ready", 64'(in_ready), 64'(occ_m != 2));
      chk("rnd_occ", 64'(occupancy), 64'(occ_m));
      chk("rnd_out_valid", 64'(out_valid), 64'(occ_m != 0));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = {$urandom(), $urandom()};
      acc_m = in_valid && (occ_m != 2);
      pop_m = (occ_m != 0) && out_ready;
      if (acc_m && !flush) sb.push_back(in_data);
      if (flush) occ_m = 0;
      else occ_m = occ_m + int'(acc_m) - int'(pop_m);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_occ", 64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
